// File: rtl/sound_tone_scheduler.sv
// Shares one square-wave tone generator between three latched, fixed-priority
// sound requesters (0 highest). One tone plays at a time; DONE marks normal completion.
module sound_tone_scheduler #(
  parameter int HALF_PERIOD_0 = 1000,
  parameter int HALF_PERIOD_1 = 500,
  parameter int HALF_PERIOD_2 = 250,
  parameter int PERIODS_0     = 16,
  parameter int PERIODS_1     = 16,
  parameter int PERIODS_2     = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ENABLE,
  input  logic [2:0] REQ,
  output logic       OUT,
  output logic       BUSY,
  output logic [1:0] ACTIVE,
  output logic       DONE
);

  localparam int MAX_HP = (HALF_PERIOD_0 > HALF_PERIOD_1)
                        ? ((HALF_PERIOD_0 > HALF_PERIOD_2) ? HALF_PERIOD_0 : HALF_PERIOD_2)
                        : ((HALF_PERIOD_1 > HALF_PERIOD_2) ? HALF_PERIOD_1 : HALF_PERIOD_2);
  localparam int MAX_PR = (PERIODS_0 > PERIODS_1)
                        ? ((PERIODS_0 > PERIODS_2) ? PERIODS_0 : PERIODS_2)
                        : ((PERIODS_1 > PERIODS_2) ? PERIODS_1 : PERIODS_2);
  // Keep at least one bit so a limit of 1 (terminal count 0) still has a counter.
  localparam int HW = ($clog2(MAX_HP) < 1) ? 1 : $clog2(MAX_HP);
  localparam int PW = ($clog2(MAX_PR) < 1) ? 1 : $clog2(MAX_PR);

  localparam logic [HW-1:0] HLIM0 = HW'(HALF_PERIOD_0 - 1);
  localparam logic [HW-1:0] HLIM1 = HW'(HALF_PERIOD_1 - 1);
  localparam logic [HW-1:0] HLIM2 = HW'(HALF_PERIOD_2 - 1);
  localparam logic [PW-1:0] PLIM0 = PW'(PERIODS_0 - 1);
  localparam logic [PW-1:0] PLIM1 = PW'(PERIODS_1 - 1);
  localparam logic [PW-1:0] PLIM2 = PW'(PERIODS_2 - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    pend_q, pend_d;
  logic [HW-1:0] half_q, half_d;
  logic [PW-1:0] per_q, per_d;
  logic [1:0]    active_q, active_d;
  logic          done_q, done_d;

  logic [HW-1:0] half_lim;
  logic [PW-1:0] per_lim;

  always_comb begin
    half_lim = HLIM0;
    per_lim  = PLIM0;
    case (active_q)
      2'd1: begin
        half_lim = HLIM1;
        per_lim  = PLIM1;
      end
      2'd2: begin
        half_lim = HLIM2;
        per_lim  = PLIM2;
      end
      default: begin
        half_lim = HLIM0;
        per_lim  = PLIM0;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    half_d   = half_q;
    per_d    = per_q;
    active_d = active_q;
    done_d   = 1'b0;

    if (!ENABLE) begin
      pend_d  = '0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (pend_q != '0) begin
            state_d = HIGH;
            half_d  = '0;
            per_d   = '0;
            if (pend_q[0]) begin
              active_d  = 2'd0;
              pend_d[0] = 1'b0;
            end else if (pend_q[1]) begin
              active_d  = 2'd1;
              pend_d[1] = 1'b0;
            end else begin
              active_d  = 2'd2;
              pend_d[2] = 1'b0;
            end
          end
        end
        HIGH: begin
          if (half_q == half_lim) begin
            state_d = LOW;
            half_d  = '0;
          end else begin
            half_d = half_q + HW'(1);
          end
        end
        LOW: begin
          if (half_q == half_lim) begin
            half_d = '0;
            if (per_q == per_lim) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              per_d   = per_q + PW'(1);
              state_d = HIGH;
            end
          end else begin
            half_d = half_q + HW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
      // A new request overrides the grant-clear, so a same-cycle repeat replays once.
      pend_d = pend_d | REQ;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      pend_q   <= '0;
      half_q   <= '0;
      per_q    <= '0;
      active_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      half_q   <= half_d;
      per_q    <= per_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  assign OUT    = (state_q == HIGH);
  assign BUSY   = (state_q != IDLE);
  assign ACTIVE = active_q;
  assign DONE   = done_q;

endmodule

// File: tb/tb_sound_tone_scheduler.sv
// Directed bench for sound_tone_scheduler: a vector table for reset, single tone and
// priority queuing, plus hand-written sequences for preemption, replay, mute and reset.
module tb_sound_tone_scheduler;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] req;
  logic       out_o;
  logic       busy_o;
  logic [1:0] active_o;
  logic       done_o;

  int unsigned errors = 0;
  int unsigned checks = 0;

  sound_tone_scheduler #(
    .HALF_PERIOD_0(3),
    .HALF_PERIOD_1(2),
    .HALF_PERIOD_2(1),
    .PERIODS_0    (2),
    .PERIODS_1    (1),
    .PERIODS_2    (3)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .ENABLE(en),
    .REQ   (req),
    .OUT   (out_o),
    .BUSY  (busy_o),
    .ACTIVE(active_o),
    .DONE  (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs apply during one cycle; expected outputs are those after the following edge.
  typedef struct {
    logic [2:0] req;
    logic       en;
    logic       rst;
    logic       eo;
    logic       eb;
    logic [1:0] ea;
    logic       ed;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [2:0] r, input logic e, input logic rs,
                              input logic o, input logic b, input logic [1:0] a,
                              input logic d);
    vec_t v;
    v.req = r; v.en = e; v.rst = rs; v.eo = o; v.eb = b; v.ea = a; v.ed = d;
    tbl.push_back(v);
  endfunction

  // Rows for a whole tone starting at its grant edge, then its DONE cycle.
  function automatic void add_tone(input logic [1:0] id, input int hp, input int np);
    for (int k = 0; k < 2 * hp * np; k++)
      add(3'b000, 1'b1, 1'b0, ((k / hp) % 2) == 0, 1'b1, id, 1'b0);
    add(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, id, 1'b1);
  endfunction

  task automatic chk(input string name, input int row, input logic [1:0] act,
                     input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step=%0d got=%b want=%b", name, row, act, exp);
    end
  endtask

  int step = 0;

  task automatic cyc(input logic [2:0] r, input logic e, input logic rs,
                     input logic o, input logic b, input logic [1:0] a, input logic d);
    req = r; en = e; rst = rs;
    @(posedge clk);
    #1;
    chk("out",    step, {1'b0, out_o},  {1'b0, o});
    chk("busy",   step, {1'b0, busy_o}, {1'b0, b});
    chk("active", step, active_o,       a);
    chk("done",   step, {1'b0, done_o}, {1'b0, d});
    step++;
  endtask

  // Remaining cycles of a tone from cycle index 'from', then its DONE cycle.
  task automatic tone_rest(input logic [1:0] id, input int hp, input int np, input int from);
    for (int k = from; k < 2 * hp * np; k++)
      cyc(3'b000, 1'b1, 1'b0, ((k / hp) % 2) == 0, 1'b1, id, 1'b0);
    cyc(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, id, 1'b1);
  endtask

  initial begin
    req = 3'b000; en = 1'b1; rst = 1'b1;

    // Reset for two cycles, then 20 idle cycles.
    add(3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    add(3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 20; i++) add(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    // Single tone for requester 0: 3 high, 3 low, twice.
    add(3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    add_tone(2'd0, 3, 2);
    add(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    // Requesters 1 and 2 together: 1 first, one DONE gap, then 2.
    add(3'b110, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    add_tone(2'd1, 2, 1);
    add_tone(2'd2, 1, 3);
    add(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0);

    for (int i = 0; i < tbl.size(); i++)
      cyc(tbl[i].req, tbl[i].en, tbl[i].rst, tbl[i].eo, tbl[i].eb, tbl[i].ea, tbl[i].ed);

    // No preemption: requests for 0 and 2 during a tone for 2.
    cyc(3'b100, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0);
    cyc(3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0);
    cyc(3'b101, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0);
    tone_rest(2'd2, 1, 3, 2);
    tone_rest(2'd0, 3, 2, 0);
    tone_rest(2'd2, 1, 3, 0);
    cyc(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0);

    // REQ[1] held across its own grant edge replays exactly once.
    cyc(3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0);
    cyc(3'b010, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0);
    tone_rest(2'd1, 2, 1, 1);
    tone_rest(2'd1, 2, 1, 0);
    for (int i = 0; i < 5; i++) cyc(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);

    // Mute in the fourth tone cycle with requester 1 pending.
    cyc(3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
    cyc(3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0);
    cyc(3'b010, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0);
    cyc(3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0);
    cyc(3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
    cyc(3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 8; i++) cyc(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);

    // Reset during LOW of a requester-1 tone with 0 and 1 pending.
    cyc(3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    cyc(3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0);
    cyc(3'b011, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0);
    cyc(3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
    cyc(3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 8; i++) cyc(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout step=%0d got=running want=finished", step);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sound_tone_scheduler.md
# sound_tone_scheduler

Shares one square-wave tone generator between three sound-event requesters (for example paddle hit, wall hit and brick hit) in the Breakout audio path. Each requester has its own half-period and tone length, both fixed by parameters. Short request pulses are latched, arbitrated by fixed priority and played one at a time. The block replaces one free-running astable per sound with a single sequenced counter and produces the tone level for the audio mixer.

## Interface
Parameters:
- HALF_PERIOD_0, default 1000: CLK cycles OUT stays high, and also cycles it stays low, for requester 0. Must be ≥1.
- HALF_PERIOD_1, default 500: same, requester 1. Must be ≥1.
- HALF_PERIOD_2, default 250: same, requester 2. Must be ≥1.
- PERIODS_0, default 16: number of full high+low periods played for requester 0. Must be ≥1.
- PERIODS_1, default 16: same, requester 1. Must be ≥1.
- PERIODS_2, default 16: same, requester 2. Must be ≥1.

Ports:
- CLK  input  1  system clock. All logic is on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- ENABLE  input  1  sound enable. Low means mute and abort.
- REQ  input  3  request pulses, one bit per requester. Level-sampled every cycle.
- OUT  output  1  tone level to the mixer.
- BUSY  output  1  high while a tone is playing (state is not IDLE).
- ACTIVE  output  2  index of the requester being played, or last played. Valid while BUSY is high.
- DONE  output  1  one-cycle pulse when a tone completes normally.

## Operation
Registers:
- pending[2:0]: sticky request latches.
- half_cnt: width $clog2 of the largest HALF_PERIOD.
- per_cnt: width $clog2 of the largest PERIODS.
- ACTIVE, state.

State machine:
- States: IDLE, HIGH, LOW.
- OUT = 1 only in HIGH. BUSY = 1 in HIGH or LOW.
- Reset: state=IDLE, pending=0, counters=0, ACTIVE=0. Outputs OUT=0, BUSY=0, ACTIVE=0, DONE=0.

Request latching:
- Each cycle, pending[i] is set when REQ[i]=1 and ENABLE=1.
- Set wins over the grant-clear in the same cycle. A same-id request arriving in its own grant cycle therefore replays once afterwards.
- A request for the id currently playing sets pending. That id replays after the current tone ends. There is no restart mid-tone.

Transitions:
- IDLE → HIGH: when ENABLE=1 and pending≠0. Grant the lowest set index (0 highest priority). In the same cycle:
  - ACTIVE ← index
  - clear pending[index]
  - half_cnt ← 0, per_cnt ← 0
- HIGH: half_cnt counts up. When half_cnt == HALF_PERIOD_ACTIVE−1, go to LOW with half_cnt ← 0.
- LOW: half_cnt counts up. When half_cnt == HALF_PERIOD_ACTIVE−1:
  - If per_cnt == PERIODS_ACTIVE−1, go to IDLE and assert DONE in the cycle after that edge.
  - Otherwise per_cnt increments, half_cnt ← 0, and state goes to HIGH.
- No preemption. A higher-priority request arriving mid-tone waits in pending.

ENABLE=0 (mute):
- pending is cleared every cycle.
- From HIGH or LOW, state goes to IDLE on the next edge. DONE is not asserted.
- ACTIVE holds its last value.

RESET:
- Overrides everything, including mid-tone. The whole block returns to its reset values on the next edge.

## Timing
- REQ[i] high at edge N → pending[i]=1 after N.
- Grant at edge N+1 → OUT=1, BUSY=1, ACTIVE valid from cycle N+1.
  - So OUT rises 2 cycles after the first sampled request, if the block is idle.
- A request already pending while IDLE is granted on the next edge.
- Each high phase lasts exactly HALF_PERIOD cycles, and so does each low phase.
- Tone length is exactly 2·HALF_PERIOD·PERIODS cycles of BUSY=1.
- Gap between back-to-back tones: exactly 1 IDLE cycle (OUT=0, BUSY=0), which is the cycle DONE=1.
- DONE coincides with the first IDLE cycle. A grant can occur on the edge ending that cycle.
- HALF_PERIOD=1: OUT toggles every cycle.
- HALF_PERIOD=1 and PERIODS=1: BUSY lasts 2 cycles.
- All outputs are registered or decoded from registered state. There are no combinational paths from REQ, ENABLE or RESET to any output.

## Test plan
Bench parameters: HALF_PERIOD_0/1/2 = 3/2/1, PERIODS_0/1/2 = 2/1/3.

- Reset then idle: RESET for 2 cycles, REQ=0 → OUT=0, BUSY=0, DONE=0, ACTIVE=0 for 20 cycles.
- Single tone: 1-cycle pulse REQ=3'b001 →
  - OUT pattern 1,1,1,0,0,0,1,1,1,0,0,0 starting 2 cycles after the pulse.
  - BUSY high for 12 cycles.
  - DONE pulses on cycle 13 with ACTIVE=0.
- Priority and queuing: REQ=3'b110 for 1 cycle →
  - Requester 1 plays first: OUT 1,1,0,0, ACTIVE=1.
  - Then 1 idle cycle with DONE=1.
  - Then requester 2 plays: OUT 1,0,1,0,1,0, ACTIVE=2.
  - Then DONE again.
- No preemption and replay:
  - While requester 2 is playing, pulse REQ[0] and REQ[2] → the tone for 2 finishes undisturbed, then 0 plays, then 2 replays.
  - REQ[1] held high across its own grant cycle → it replays exactly once more.
- Mute mid-tone: ENABLE=0 in cycle 4 of a requester-0 tone →
  - BUSY=0 and OUT=0 from the next cycle. DONE stays 0.
  - pending is cleared: re-enabling with REQ=0 produces no tone.
- Reset mid-tone: RESET=1 for 1 cycle during LOW, with pending=3'b011 → all outputs at reset values on the next cycle. Nothing plays afterwards without new requests.
